// File: rtl/lambda_dispatch.sv
// lambda_dispatch: issues two-operand calls round-robin to a bank of
// NUM_UNITS external function units and returns results in issue order.

// Per-unit bookkeeping: busy flag plus a capture register for results that
// finish before the unit reaches the head of the order queue.
module lambda_dispatch_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue,
  input  logic             retire,
  input  logic             done,
  input  logic [WIDTH-1:0] done_data,
  output logic             busy,
  output logic             cap_flag,
  output logic [WIDTH-1:0] cap_reg
);

  // Busy from issue until delivered; capture only results from a busy unit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      cap_flag <= 1'b0;
      cap_reg  <= '0;
    end else begin
      if (retire)     busy <= 1'b0;
      else if (issue) busy <= 1'b1;
      if (retire)            cap_flag <= 1'b0;
      else if (done && busy) cap_flag <= 1'b1;
      if (done && busy) cap_reg <= done_data;
    end
  end

endmodule

module lambda_dispatch #(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 2,
  parameter int UIDX_W    = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       request,
  input  logic [WIDTH-1:0]           in1,
  input  logic [WIDTH-1:0]           in2,
  output logic                       ready,
  output logic                       out,
  output logic [WIDTH-1:0]           result,
  output logic [NUM_UNITS-1:0]       unit_request,
  output logic [WIDTH-1:0]           unit_in1,
  output logic [WIDTH-1:0]           unit_in2,
  input  logic [NUM_UNITS-1:0]       unit_out,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
  output logic [UIDX_W:0]            outstanding,
  output logic                       proto_err
);

  logic [NUM_UNITS-1:0]            busy, cap_flag, issue_vec, retire_vec;
  logic [NUM_UNITS-1:0][WIDTH-1:0] cap_reg, ures;
  logic [UIDX_W-1:0]               q_mem [NUM_UNITS];
  logic [UIDX_W-1:0]               wr_ptr, rd_ptr, rr, pick, head;
  logic [UIDX_W:0]                 q_cnt;
  logic                            accept, deliver;
  logic [WIDTH-1:0]                deliver_data;

  assign ures        = unit_result;
  assign head        = q_mem[rd_ptr];
  assign outstanding = q_cnt;
  assign ready       = (~&busy) && (q_cnt < (UIDX_W+1)'(NUM_UNITS));
  assign accept      = request && ready;

  function automatic logic [UIDX_W-1:0] wrap_inc(input logic [UIDX_W-1:0] p);
    return (p == UIDX_W'(NUM_UNITS-1)) ? '0 : p + 1'b1;
  endfunction

  // First idle unit at or after the round-robin pointer, using pre-edge busy.
  always_comb begin
    int j;
    logic found;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      j = int'(rr) + i;
      if (j >= NUM_UNITS) j = j - NUM_UNITS;
      if (!found && !busy[j]) begin
        found = 1'b1;
        pick  = UIDX_W'(j);
      end
    end
  end

  // Head-of-queue delivery; a same-cycle done pulse bypasses the capture reg.
  always_comb begin
    deliver      = 1'b0;
    deliver_data = '0;
    if (q_cnt != '0) begin
      deliver      = cap_flag[head] || unit_out[head];
      deliver_data = cap_flag[head] ? cap_reg[head] : ures[head];
    end
  end

  // Per-unit issue/retire strobes.
  always_comb begin
    issue_vec  = '0;
    retire_vec = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      issue_vec[k]  = accept  && (pick == UIDX_W'(k));
      retire_vec[k] = deliver && (head == UIDX_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_slot
    lambda_dispatch_slot #(.WIDTH(WIDTH)) u_slot (
      .clock    (clock),
      .reset    (reset),
      .issue    (issue_vec[g]),
      .retire   (retire_vec[g]),
      .done     (unit_out[g]),
      .done_data(ures[g]),
      .busy     (busy[g]),
      .cap_flag (cap_flag[g]),
      .cap_reg  (cap_reg[g])
    );
  end

  // Order queue storage; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (accept) q_mem[wr_ptr] <= pick;
  end

  // Issue/deliver registers, queue pointers, rr pointer and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out          <= 1'b0;
      result       <= '0;
      unit_request <= '0;
      unit_in1     <= '0;
      unit_in2     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      q_cnt        <= '0;
      rr           <= '0;
      proto_err    <= 1'b0;
    end else begin
      unit_request <= issue_vec;
      out          <= deliver;
      if (accept) begin
        unit_in1 <= in1;
        unit_in2 <= in2;
        wr_ptr   <= wrap_inc(wr_ptr);
        rr       <= wrap_inc(pick);
      end
      if (deliver) begin
        result <= deliver_data;
        rd_ptr <= wrap_inc(rd_ptr);
      end
      case ({accept, deliver})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
      if (|(unit_out & ~busy)) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lambda_dispatch.sv
// Bench for lambda_dispatch: emulated adder units with per-call latency,
// reference model of call ordering kept as queues of issued calls.
module tb_lambda_dispatch;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int UW = 2;

  logic           clock = 1'b0, reset = 1'b0, request = 1'b0;
  logic [W-1:0]   in1 = '0, in2 = '0;
  logic           ready, out, proto_err;
  logic [W-1:0]   result, unit_in1, unit_in2;
  logic [N-1:0]   unit_request;
  logic [N-1:0]   unit_out = '0;
  logic [N*W-1:0] unit_result = '0;
  logic [UW:0]    outstanding;

  lambda_dispatch #(.WIDTH(W), .NUM_UNITS(N), .UIDX_W(UW)) dut (
    .clock(clock), .reset(reset), .request(request), .in1(in1), .in2(in2),
    .ready(ready), .out(out), .result(result), .unit_request(unit_request),
    .unit_in1(unit_in1), .unit_in2(unit_in2), .unit_out(unit_out),
    .unit_result(unit_result), .outstanding(outstanding), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [W-1:0] a, b; int lat; } call_t;

  int checks = 0, failures = 0;
  // reference model: calls in issue order, per-unit busy/done
  bit m_busy[N], m_done[N], m_proto;
  int mq[$];
  logic [W-1:0] mv[$];
  int m_rr;
  bit e_out;
  logic [W-1:0] e_res, e_in1, e_in2;
  logic [N-1:0] e_ureq;
  // unit emulator and caller
  int tmr[N];
  logic [W-1:0] uval[N];
  int lat_q[$];
  logic [N-1:0] inj = '0;
  call_t call_q[$];
  bit pend;
  logic [W-1:0] pa, pb;
  int pl;
  bit rnd_on, rst_req, saw_full;
  int cyc, last_out_cyc, last_uo_cyc[N];
  int iss_log[$];
  logic [W-1:0] dlv_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_ready();
    bit idle = 1'b0;
    for (int k = 0; k < N; k++) if (!m_busy[k]) idle = 1'b1;
    return idle && (mq.size() < N);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin m_busy[k] = 0; m_done[k] = 0; end
    mq.delete(); mv.delete(); lat_q.delete();
    m_rr = 0; m_proto = 0; e_out = 0; e_ureq = '0; pend = 0;
  endtask

  task automatic tick();
    logic [N-1:0] uo;
    int pick, h, j;
    bit acc;
    @(negedge clock);
    cyc++;
    reset = 1'b1;
    chk("ready", ready, m_ready());
    chk("outstanding", outstanding, mq.size());
    chk("out", out, e_out);
    if (e_out) chk("result", result, e_res);
    chk("unit_request", unit_request, e_ureq);
    if (e_ureq != '0) begin
      chk("unit_in1", unit_in1, e_in1);
      chk("unit_in2", unit_in2, e_in2);
    end
    chk("proto_err", proto_err, m_proto);
    if (outstanding == N && !ready) saw_full = 1;
    if (out) begin dlv_log.push_back(result); last_out_cyc = cyc; end
    // emulated units: result = sum of operands, done after lat cycles
    uo = '0;
    for (int k = 0; k < N; k++)
      if (tmr[k] > 0) begin
        tmr[k]--;
        if (tmr[k] == 0) uo[k] = 1'b1;
      end
    for (int k = 0; k < N; k++)
      if (unit_request[k]) begin
        iss_log.push_back(k);
        tmr[k]  = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        uval[k] = unit_in1 + unit_in2;
      end
    uo = uo | inj;
    inj = '0;
    for (int k = 0; k < N; k++) begin
      unit_result[k*W +: W] = uo[k] ? uval[k] : W'($urandom());
      if (uo[k]) last_uo_cyc[k] = cyc;
    end
    unit_out = uo;
    if (rst_req) begin
      rst_req = 0;
      reset   = 1'b0;
      request = 1'b0;
      model_clear();
      return;
    end
    // caller: hold request until accepted
    if (!pend) begin
      if (call_q.size() > 0) begin
        call_t c = call_q.pop_front();
        pend = 1; pa = c.a; pb = c.b; pl = c.lat;
      end else if (rnd_on && $urandom_range(99) < 60) begin
        pend = 1; pa = $urandom(); pb = $urandom(); pl = $urandom_range(1, 8);
      end
    end
    request = pend;
    in1 = pend ? pa : W'($urandom());
    in2 = pend ? pb : W'($urandom());
    // model of the coming edge
    acc  = pend && m_ready();
    pick = -1;
    if (acc)
      for (int i = 0; i < N; i++) begin
        j = (m_rr + i) % N;
        if (pick < 0 && !m_busy[j]) pick = j;
      end
    for (int k = 0; k < N; k++)
      if (uo[k]) begin
        if (!m_busy[k]) m_proto = 1;
        else            m_done[k] = 1;
      end
    e_out = 0;
    if (mq.size() > 0 && m_done[mq[0]]) begin
      h = mq.pop_front();
      e_res = mv.pop_front();
      e_out = 1;
      m_busy[h] = 0;
      m_done[h] = 0;
    end
    e_ureq = '0;
    if (acc) begin
      m_busy[pick] = 1;
      mq.push_back(pick);
      mv.push_back(pa + pb);
      lat_q.push_back(pl);
      m_rr = (pick + 1) % N;
      e_ureq[pick] = 1'b1;
      e_in1 = pa; e_in2 = pb;
      pend = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() > 0 || pend || call_q.size() > 0) && n < 400) begin
      tick(); n++;
    end
    chk("drain_timeout", n < 400, 1);
    tick(); tick();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin tmr[k] = 0; uval[k] = '0; last_uo_cyc[k] = 0; end
    model_clear();
    repeat (3) @(negedge clock);
    chk("rst_out", out, 0);
    chk("rst_result", result, 0);
    chk("rst_ureq", unit_request, 0);
    chk("rst_in1", unit_in1, 0);
    chk("rst_in2", unit_in2, 0);
    chk("rst_outst", outstanding, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_ready", ready, 1);
    reset = 1'b1;

    // saturation: 6 held calls, ready must drop at 4 outstanding
    iss_log.delete(); dlv_log.delete(); saw_full = 0;
    for (int i = 1; i <= 6; i++)
      call_q.push_back('{a: W'(i*10), b: W'(i), lat: 2 + (i % 4)});
    drain();
    chk("sat_full", saw_full, 1);
    chk("sat_nissue", iss_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("sat_unit", iss_log[i], i % N);
    chk("sat_ndlv", dlv_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("sat_order", dlv_log[i], 11*(i+1));

    // single call 5+7, latency 3 (rr now at unit 2)
    iss_log.delete(); dlv_log.delete();
    call_q.push_back('{a: 5, b: 7, lat: 3});
    drain();
    chk("one_unit", iss_log[0], 2);
    chk("one_result", dlv_log[0], 12);
    chk("one_lat", last_out_cyc - last_uo_cyc[2], 1);

    // out-of-order completion: slow A, fast B
    iss_log.delete(); dlv_log.delete();
    call_q.push_back('{a: 1, b: 1, lat: 6});
    call_q.push_back('{a: 2, b: 2, lat: 1});
    drain();
    chk("ooo_n", dlv_log.size(), 2);
    chk("ooo_first", dlv_log[0], 2);
    chk("ooo_second", dlv_log[1], 4);

    // round-robin wrap with sequential calls
    iss_log.delete();
    for (int i = 0; i < 3; i++) begin
      call_q.push_back('{a: W'(i), b: 1, lat: 1});
      drain();
    end
    chk("rr_u0", iss_log[0], 1);
    chk("rr_u1", iss_log[1], 2);
    chk("rr_u2", iss_log[2], 3);

    // random traffic
    rnd_on = 1;
    repeat (400) tick();
    rnd_on = 0;
    drain();

    // done pulse from an idle unit
    inj = 4'b0010;
    tick(); tick();
    chk("perr_set", proto_err, 1);
    chk("perr_out", out, 0);
    chk("perr_outst", outstanding, 0);
    repeat (3) tick();
    chk("perr_sticky", proto_err, 1);

    // reset with two calls in flight
    call_q.push_back('{a: 3, b: 3, lat: 30});
    call_q.push_back('{a: 4, b: 4, lat: 30});
    repeat (4) tick();
    chk("mid_outst", outstanding, 2);
    rst_req = 1;
    tick(); tick();
    chk("mid_rst_outst", outstanding, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_out", out, 0);
    iss_log.delete(); dlv_log.delete();
    call_q.push_back('{a: 9, b: 9, lat: 2});
    drain();
    chk("mid_next_unit", iss_log[0], 0);
    chk("mid_next_res", dlv_log[0], 18);
    repeat (40) tick();
    chk("mid_stale_perr", proto_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
